dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: DEPTH, 1024, number of 32-bit words; power of two, >= 4.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: req_valid  input  1  request present.
REQ-005 Port: req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 Port: req_we  input  1  1 = store, 0 = load.
REQ-007 Port: req_funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 Port: req_addr  input  32  byte address.
REQ-009 Port: req_wdata  input  32  store data; low 8/16/32 bits used per size.
REQ-010 Port: resp_valid  output  1  response present.
REQ-011 Port: resp_ready  input  1  response consumed when resp_valid && resp_ready.
REQ-012 Port: resp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-013 Port: resp_err  output  1  request rejected: illegal funct3, out of range, or misaligned.

Function
REQ-014 States: IDLE, RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-015 IDLE -> RESP on accept; RESP -> IDLE when resp_ready = 1; otherwise RESP holds with resp_rdata/resp_err stable.
REQ-016 Latency: response valid the cycle after accept; max throughput one request per 2 cycles; one outstanding request.
REQ-017 Word index = req_addr[31:2]; index >= DEPTH -> resp_err = 1, no memory access.
REQ-018 Store writes memory at the accept edge; only selected byte lanes change: B lane addr[1:0], H lanes {addr[1],0} and {addr[1],1}, W all four.
REQ-019 Store with funct3 100, 101, 011, 11x, or load with 011, 11x -> resp_err = 1, no write, resp_rdata = 0.
REQ-020 Load samples memory at accept edge; B/H sign-extend, BU/HU zero-extend, lane selected by addr[1:0] as in REQ-018.
REQ-021 Load data reflects all stores accepted earlier; no same-cycle read/write conflict exists (one access per accept).
REQ-022 resp_err = 1 implies resp_rdata = 0 and memory unchanged.
REQ-023 Memory contents are 0 at time zero.

Reset
REQ-024 rst = 1 at rising edge: state IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0; req_ready = 1 the cycle after.
REQ-025 Reset does not clear memory; a store accepted before reset stays committed, even if its response was pending.
REQ-026 Request presented during a reset cycle is not accepted and causes no write.

Configuration
REQ-027 Macro DMEM_MISALIGN_TRAP_EN defined: H/HU with addr[0] = 1, or W with addr[1:0] != 0 -> resp_err = 1, no write, resp_rdata = 0.
REQ-028 DMEM_MISALIGN_TRAP_EN undefined: no misalign error; H/HU ignore addr[0], W ignores addr[1:0] (access at aligned lanes).

Verification
REQ-029 Reset, SW addr 0x10 data 0xDEADBEEF, LW addr 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0, each response one cycle after accept.
REQ-030 SW 0x20 = 0x00000000, SB addr 0x23 data 0x80, LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LW 0x20 -> 0x80000000.
REQ-031 SH addr 0x32 data 0x8001, LH 0x32 -> 0xFFFF8001, LHU 0x32 -> 0x00008001, LHU 0x30 -> 0x00000000.
REQ-032 Load accepted, resp_ready held 0 for 3 cycles -> resp_valid and resp_rdata stable, req_ready 0; released -> IDLE next cycle.
REQ-033 SW addr 4*DEPTH, and store funct3 100 -> resp_err 1, no memory change (readback of addr 0 unchanged).
REQ-034 SW addr 0x41 data 0x12345678: with DMEM_MISALIGN_TRAP_EN -> resp_err 1, LW 0x40 = 0; without -> resp_err 0, LW 0x40 = 0x12345678.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/response bus of the data memory controller
interface dmem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - single-outstanding byte/half/word data memory controller
// Optional macro DMEM_MISALIGN_TRAP_EN: reject misaligned halfword/word accesses.
module dmem_ctrl #(
   parameter int DEPTH = 1024
) (
   input  logic       clk,
   input  logic       rst,
   dmem_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [29:0] DEPTH_W = 30'(DEPTH);

   typedef enum logic {IDLE, RESP} state_t;

   state_t      state_q, state_d;
   logic        accept;
   logic        f3_ok, in_range, misalign, err;
   logic [1:0]  lane;
   logic [3:0]  be;
   logic [31:0] wr_word, rd_word, rd_shift, rd_ext;
   logic [AW-1:0] mem_idx;
   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] mem [DEPTH] = '{default: 32'h0};

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      accept         = 1'b0;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            // a request seen while reset is asserted must not commit anything
            if (bus.req_valid && !rst) begin
               accept  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_idx  = bus.req_addr[AW+1:2];
      in_range = bus.req_addr[31:2] < DEPTH_W;
      case (bus.req_funct3)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = !bus.req_we;
         default:                f3_ok = 1'b0;
      endcase
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
      misalign = 1'b0;
`endif
      err = !f3_ok || !in_range || misalign;
      case (bus.req_funct3[1:0])
         2'b10:   lane = 2'b00;
         2'b01:   lane = {bus.req_addr[1], 1'b0};
         default: lane = bus.req_addr[1:0];
      endcase
      case (bus.req_funct3[1:0])
         2'b00: begin
            be      = 4'b0001 << lane;
            wr_word = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            be      = 4'b0011 << lane;
            wr_word = {2{bus.req_wdata[15:0]}};
         end
         default: begin
            be      = 4'b1111;
            wr_word = bus.req_wdata;
         end
      endcase
      rd_word  = mem[mem_idx];
      rd_shift = rd_word >> {lane, 3'b000};
      case (bus.req_funct3)
         3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b100:  rd_ext = {24'h0, rd_shift[7:0]};
         3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b101:  rd_ext = {16'h0, rd_shift[15:0]};
         default: rd_ext = rd_word;
      endcase
   end

   // memory is deliberately outside the reset domain
   always_ff @(posedge clk) begin
      if (accept && bus.req_we && !err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[mem_idx][8*i +: 8] <= wr_word[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else if (accept) begin
         err_q   <= err;
         rdata_q <= (err || bus.req_we) ? 32'h0 : rd_ext;
      end
   end

   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl against a byte-array model
module tb_dmem_ctrl;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [7:0] ref_mem [4*DEPTH];

   dmem_ctrl_if bif ();

   dmem_ctrl #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: byte-addressed memory, size/sign/legality from the access rules.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata, output logic e);
      int size;
      int base;
      logic legal;
      logic [31:0] v;
      size  = 1 << f3[1:0];
      legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                 : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      e = !legal || ({32'h0, addr} >> 2) >= 64'(DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
      if (legal && (addr % size) != 0) e = 1'b1;
`endif
      rdata = 32'h0;
      if (e) return;
      base = int'(addr) - int'(addr % size);
      if (we) begin
         for (int b = 0; b < size; b++) ref_mem[base + b] = wd[8*b +: 8];
      end else begin
         v = 32'h0;
         for (int b = 0; b < size; b++) v = v | (32'(ref_mem[base + b]) << (8*b));
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
         rdata = v;
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold, input string tag,
                         input logic [32:0] kexp);
      logic [31:0] exp_d;
      logic        exp_e;
      model(we, f3, addr, wd, exp_d, exp_e);
      @(negedge clk);
      bif.req_valid  = 1'b1;
      bif.req_we     = we;
      bif.req_funct3 = f3;
      bif.req_addr   = addr;
      bif.req_wdata  = wd;
      bif.resp_ready = (hold == 0);
      check({tag, "_req_ready"}, 32'(bif.req_ready), 32'h1);
      @(posedge clk);
      #1;
      bif.req_valid = 1'b0;
      check({tag, "_resp_valid"}, 32'(bif.resp_valid), 32'h1);
      check({tag, "_rdata"}, bif.resp_rdata, exp_d);
      check({tag, "_err"}, 32'(bif.resp_err), 32'(exp_e));
      if (kexp[32]) check({tag, "_known"}, bif.resp_rdata, kexp[31:0]);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_valid"}, 32'(bif.resp_valid), 32'h1);
         check({tag, "_hold_rdata"}, bif.resp_rdata, exp_d);
         check({tag, "_hold_err"}, 32'(bif.resp_err), 32'(exp_e));
         check({tag, "_hold_ready"}, 32'(bif.req_ready), 32'h0);
      end
      bif.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_done_valid"}, 32'(bif.resp_valid), 32'h0);
      check({tag, "_done_ready"}, 32'(bif.req_ready), 32'h1);
   endtask

   initial begin
      logic [31:0] ra, rw;
      logic [2:0]  rf;
      logic        rwe;
      logic [31:0] sink_d;
      logic        sink_e;

      for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
      bif.req_valid  = 1'b0;
      bif.req_we     = 1'b0;
      bif.req_funct3 = 3'b010;
      bif.req_addr   = 32'h0;
      bif.req_wdata  = 32'h0;
      bif.resp_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_resp_valid", 32'(bif.resp_valid), 32'h0);
      check("rst_rdata", bif.resp_rdata, 32'h0);
      check("rst_err", 32'(bif.resp_err), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      check("rst_req_ready", 32'(bif.req_ready), 32'h1);

      do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw10", 33'h0);
      do_req(0, 3'b010, 32'h10, 32'h0, 0, "lw10", {1'b1, 32'hDEADBEEF});

      do_req(1, 3'b010, 32'h20, 32'h0, 0, "sw20", 33'h0);
      do_req(1, 3'b000, 32'h23, 32'h80, 0, "sb23", 33'h0);
      do_req(0, 3'b000, 32'h23, 32'h0, 0, "lb23", {1'b1, 32'hFFFFFF80});
      do_req(0, 3'b100, 32'h23, 32'h0, 0, "lbu23", {1'b1, 32'h00000080});
      do_req(0, 3'b010, 32'h20, 32'h0, 0, "lw20", {1'b1, 32'h80000000});

      do_req(1, 3'b001, 32'h32, 32'h8001, 0, "sh32", 33'h0);
      do_req(0, 3'b001, 32'h32, 32'h0, 0, "lh32", {1'b1, 32'hFFFF8001});
      do_req(0, 3'b101, 32'h32, 32'h0, 0, "lhu32", {1'b1, 32'h00008001});
      do_req(0, 3'b101, 32'h30, 32'h0, 0, "lhu30", {1'b1, 32'h00000000});

      do_req(0, 3'b010, 32'h10, 32'h0, 3, "lw_stall", {1'b1, 32'hDEADBEEF});

      do_req(1, 3'b010, 32'h0, 32'hCAFE0001, 0, "sw0", 33'h0);
      do_req(1, 3'b010, 32'(4*DEPTH), 32'h11111111, 0, "sw_oor", 33'h0);
      do_req(1, 3'b100, 32'h0, 32'h22222222, 0, "sbu_bad", 33'h0);
      do_req(1, 3'b011, 32'h0, 32'h33333333, 0, "s011_bad", 33'h0);
      do_req(0, 3'b110, 32'h0, 32'h0, 0, "l110_bad", 33'h0);
      do_req(0, 3'b010, 32'h0, 32'h0, 0, "lw0_after_err", {1'b1, 32'hCAFE0001});

      do_req(1, 3'b010, 32'h41, 32'h12345678, 0, "sw41", 33'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
      do_req(0, 3'b010, 32'h40, 32'h0, 0, "lw40", {1'b1, 32'h00000000});
`else
      do_req(0, 3'b010, 32'h40, 32'h0, 0, "lw40", {1'b1, 32'h12345678});
`endif

      // store left pending across a reset stays committed
      model(1, 3'b010, 32'h60, 32'h11223344, sink_d, sink_e);
      @(negedge clk);
      bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_funct3 = 3'b010;
      bif.req_addr = 32'h60; bif.req_wdata = 32'h11223344; bif.resp_ready = 1'b0;
      @(posedge clk);
      #1;
      bif.req_valid = 1'b0;
      check("pend_resp_valid", 32'(bif.resp_valid), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("pend_rst_valid", 32'(bif.resp_valid), 32'h0);
      check("pend_rst_rdata", bif.resp_rdata, 32'h0);
      check("pend_rst_err", 32'(bif.resp_err), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bif.resp_ready = 1'b1;
      check("pend_rst_ready", 32'(bif.req_ready), 32'h1);
      do_req(0, 3'b010, 32'h60, 32'h0, 0, "lw60", {1'b1, 32'h11223344});

      // request during reset must not write
      @(negedge clk);
      rst = 1'b1;
      bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_funct3 = 3'b010;
      bif.req_addr = 32'h50; bif.req_wdata = 32'hAAAA5555;
      @(posedge clk);
      #1;
      check("rstreq_valid", 32'(bif.resp_valid), 32'h0);
      @(negedge clk);
      bif.req_valid = 1'b0;
      rst = 1'b0;
      do_req(0, 3'b010, 32'h50, 32'h0, 0, "lw50", {1'b1, 32'h00000000});

      for (int n = 0; n < 200; n++) begin
         rwe = 1'($urandom_range(0, 1));
         rf  = 3'($urandom_range(0, 7));
         rw  = $urandom;
         case ($urandom_range(0, 7))
            0:       ra = 32'(4*DEPTH) + 32'($urandom_range(0, 4095));
            1:       ra = $urandom | 32'h8000_0000;
            2, 3:    ra = 32'($urandom_range(0, 4*DEPTH - 1));
            default: ra = 32'($urandom_range(0, 31));
         endcase
         do_req(rwe, rf, ra, rw, ($urandom_range(0, 4) == 0) ? 2 : 0, "rnd", 33'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
